// File: rtl/wb_regfile_pkg.sv
// Shared sizing and constants for the miniRISC write-back register file.
package wb_regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 5;
  localparam int DEF_NUM_REGS = 32;

  // Architectural zero register; never written, always reads 0.
  localparam int REG_ZERO = 0;

endpackage

// File: rtl/wb_regfile_rf_read_bypass.sv
// Combinational operand read mux.
// R0 reads as zero. A matching pending write is forwarded in place of the
// stale array entry.
module rf_read_bypass
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              pend_valid,
  input  logic [ADDR_W-1:0] pend_addr,
  input  logic [DATA_W-1:0] pend_data,
  output logic [DATA_W-1:0] rd_data
);

  // Zero register first, then the newest accepted write, then the array.
  always_comb begin
    rd_data = rf_data;
    if (rd_addr == ADDR_W'(REG_ZERO)) begin
      rd_data = '0;
    end else if (pend_valid && (pend_addr == rd_addr)) begin
      rd_data = pend_data;
    end
  end

endmodule

// File: rtl/wb_regfile.sv
// Write-back register stage and 32x32 register file for the miniRISC datapath.
// Each write is held for one cycle in a pending entry, then committed to the
// array. Operand reads bypass from the pending entry. The debug read sees only
// the array.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_REGS = DEF_NUM_REGS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              wb_en,
  input  logic              stall,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wb_pending
);

  logic              pend_valid;
  logic [ADDR_W-1:0] pend_addr;
  logic [DATA_W-1:0] pend_data;
  logic [DATA_W-1:0] rf [NUM_REGS];

  // Pending-write capture.
  // A stall drops the request rather than holding it, so upstream must
  // re-present it. Writes aimed at R0 are never marked valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_addr  <= '0;
      pend_data  <= '0;
    end else if (stall) begin
      pend_valid <= 1'b0;
    end else begin
      pend_valid <= wb_en && (wb_addr != ADDR_W'(REG_ZERO));
      pend_addr  <= wb_addr;
      pend_data  <= wb_data;
    end
  end

  // Array commit of the previous cycle's pending write.
  // Reset clears every entry and discards the pending write, so no partial
  // commit can happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        rf[i] <= '0;
      end
    end else if (pend_valid) begin
      rf[pend_addr] <= pend_data;
    end
  end

  rf_read_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_a (
    .rd_addr   (rs_addr),
    .rf_data   (rf[rs_addr]),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .rd_data   (rs_data)
  );

  rf_read_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_port_b (
    .rd_addr   (rt_addr),
    .rf_data   (rf[rt_addr]),
    .pend_valid(pend_valid),
    .pend_addr (pend_addr),
    .pend_data (pend_data),
    .rd_data   (rt_data)
  );

  assign dbg_data   = (dbg_addr == ADDR_W'(REG_ZERO)) ? '0 : rf[dbg_addr];
  assign wb_pending = pend_valid;

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile.
// The reference model treats the register file as two views:
//   - arch: what the operand ports show, which is the latest accepted write
//     per register.
//   - committed: what the debug port shows, which is arch as it stood one
//     edge earlier.
module tb_wb_regfile;

  logic        clk;
  logic        rst;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_en;
  logic        stall;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic        wb_pending;

  int vec_count  = 0;
  int miss_count = 0;

  logic [31:0] arch      [32];
  logic [31:0] committed [32];
  logic        pend_m;

  typedef struct {
    logic        stall;
    logic        en;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] exp_rs;
    logic [31:0] exp_rt;
    logic [31:0] exp_dbg;
    logic        exp_pend;
  } vec_t;

  vec_t vecs[$];

  wb_regfile dut (
    .clk       (clk),
    .rst       (rst),
    .wb_data   (wb_data),
    .wb_addr   (wb_addr),
    .wb_en     (wb_en),
    .stall     (stall),
    .rs_addr   (rs_addr),
    .rt_addr   (rt_addr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wb_pending(wb_pending)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends on its own.
  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] time limit expired");
  end

  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      arch[i]      = '0;
      committed[i] = '0;
    end
    pend_m = 1'b0;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, let the rising edge act,
  // advance the model, then settle 1 ns past the edge for checking.
  task automatic applyStimulus(input logic s, input logic e, input logic [4:0] a,
                               input logic [31:0] d, input logic [4:0] ra,
                               input logic [4:0] rb, input logic [4:0] rd);
    logic accepted;
    @(negedge clk);
    stall    = s;
    wb_en    = e;
    wb_addr  = a;
    wb_data  = d;
    rs_addr  = ra;
    rt_addr  = rb;
    dbg_addr = rd;
    @(posedge clk);
    accepted = !s && e && (a != 5'd0);
    for (int i = 0; i < 32; i++) committed[i] = arch[i];
    if (accepted) arch[a] = d;
    pend_m = accepted;
    #1;
  endtask

  task automatic checkModel(input string tag);
    checkOutput({tag, " rs_data"},    rs_data,           arch[rs_addr]);
    checkOutput({tag, " rt_data"},    rt_data,           arch[rt_addr]);
    checkOutput({tag, " dbg_data"},   dbg_data,          committed[dbg_addr]);
    checkOutput({tag, " wb_pending"}, {31'd0, wb_pending}, {31'd0, pend_m});
  endtask

  initial begin
    rst      = 1'b1;
    stall    = 1'b0;
    wb_en    = 1'b1;
    wb_addr  = 5'd4;
    wb_data  = 32'hFFFF_FFFF;
    rs_addr  = '0;
    rt_addr  = '0;
    dbg_addr = '0;
    modelReset();

    // Every index reads zero while reset is held, even with a write offered.
    repeat (2) @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      rs_addr  = 5'(i);
      rt_addr  = 5'(31 - i);
      dbg_addr = 5'(i);
      #1;
      checkOutput("reset rs_data",  rs_data,  32'd0);
      checkOutput("reset rt_data",  rt_data,  32'd0);
      checkOutput("reset dbg_data", dbg_data, 32'd0);
    end
    checkOutput("reset wb_pending", {31'd0, wb_pending}, 32'd0);
    @(negedge clk);
    rst   = 1'b0;
    wb_en = 1'b0;

    // Directed table: write/read latency, R0, stall drop, back-to-back.
    vecs.push_back('{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 5'd5,
                     32'hDEADBEEF, 32'hDEADBEEF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0, 5'd5,
                     32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 5'd0,
                     32'h0, 32'hDEADBEEF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0,
                     32'h0, 32'h0, 32'h0, 1'b0});
    for (int k = 0; k < 3; k++)
      vecs.push_back('{1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd7, 5'd7,
                       32'h0, 32'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 5'd7, 32'hA5A5A5A5, 5'd7, 5'd5, 5'd7,
                     32'hA5A5A5A5, 32'hDEADBEEF, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7,
                     32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 5'd9, 32'h1, 5'd9, 5'd9, 5'd9,
                     32'h1, 32'h1, 32'h0, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 5'd9, 32'h2, 5'd9, 5'd9, 5'd9,
                     32'h2, 32'h2, 32'h1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 5'd9, 32'h0, 5'd9, 5'd9, 5'd9,
                     32'h2, 32'h2, 32'h2, 1'b0});

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].stall, vecs[k].en, vecs[k].addr, vecs[k].data,
                    vecs[k].rs, vecs[k].rt, vecs[k].dbg);
      checkOutput("table rs_data",  rs_data,  vecs[k].exp_rs);
      checkOutput("table rt_data",  rt_data,  vecs[k].exp_rt);
      checkOutput("table dbg_data", dbg_data, vecs[k].exp_dbg);
      checkOutput("table wb_pending", {31'd0, wb_pending}, {31'd0, vecs[k].exp_pend});
    end

    // Mid-operation reset: the accepted write must never reach the array.
    applyStimulus(1'b0, 1'b1, 5'd3, 32'hCAFEF00D, 5'd3, 5'd3, 5'd3);
    checkOutput("midrst bypass", rs_data, 32'hCAFEF00D);
    checkOutput("midrst pending before", {31'd0, wb_pending}, 32'd1);
    wb_en = 1'b0;
    #2 rst = 1'b1;
    modelReset();
    #1;
    checkOutput("midrst async pending", {31'd0, wb_pending}, 32'd0);
    checkOutput("midrst async rs_data", rs_data, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5, 5'd3);
    checkOutput("midrst rf3 dbg",   dbg_data, 32'd0);
    checkOutput("midrst rs_data",   rs_data,  32'd0);
    checkOutput("midrst rt_data",   rt_data,  32'd0);
    checkOutput("midrst wb_pending", {31'd0, wb_pending}, 32'd0);

    // Random traffic against the model, using a small address pool so that
    // collisions and bypass hits are frequent.
    for (int n = 0; n < 400; n++) begin
      applyStimulus(($urandom_range(3) == 0), 1'($urandom),
                    5'($urandom_range(7)), $urandom,
                    5'($urandom_range(7)), 5'($urandom_range(7)),
                    5'($urandom_range(7)));
      checkModel("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
